// File: rtl/led_fader_pkg.sv
// Shared types and constants for the LED fader: per-channel fade state, full-duty level
// and default timing parameters. Optional busy output is selected with LED_FADER_BUSY_EN.
package led_fader_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fade_state_e;

    localparam logic [7:0] FULL_DUTY        = 8'd255;
    localparam int unsigned DEFAULT_PRESCALE = 4;
    localparam int unsigned DEFAULT_STEP     = 51;

endpackage : led_fader_pkg

// File: rtl/led_fader_channel.sv
// One LED channel: fade state, 8-bit duty and the registered PWM output flop.
// Under LED_FADER_BUSY_EN the channel also reports whether it is mid-fade.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int unsigned STEP = DEFAULT_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_i,
    input  logic       fade_en_i,
    input  logic       period_end_i,
    input  logic [7:0] pwm_cnt_i,
    output logic       led_o
`ifdef LED_FADER_BUSY_EN
    ,
    output logic       fading_o
`endif
);

    localparam logic [8:0] STEP_W = 9'(STEP);

    fade_state_e state_q, state_d;
    logic [7:0]  duty_q, duty_d;
    logic        led_q;

    logic [8:0]  sum_w;
    logic [8:0]  diff_w;
    logic [7:0]  duty_up;
    logic [7:0]  duty_dn;

    // Saturating step arithmetic; the ninth bit catches overflow and borrow.
    assign sum_w   = {1'b0, duty_q} + STEP_W;
    assign diff_w  = {1'b0, duty_q} - STEP_W;
    assign duty_up = (sum_w >= {1'b0, FULL_DUTY}) ? FULL_DUTY : sum_w[7:0];
    assign duty_dn = diff_w[8] ? 8'd0 : diff_w[7:0];

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_OFF: begin
                if (level_i) begin
                    state_d = ST_RISE;
                end
            end
            ST_ON: begin
                if (!level_i) begin
                    state_d = ST_FALL;
                end
            end
            ST_RISE: begin
                if (!fade_en_i) begin
                    duty_d  = level_i ? FULL_DUTY : 8'd0;
                    state_d = level_i ? ST_ON : ST_OFF;
                end else if (!level_i) begin
                    state_d = ST_FALL;
                end else if (period_end_i) begin
                    duty_d = duty_up;
                    if (duty_up == FULL_DUTY) begin
                        state_d = ST_ON;
                    end
                end
            end
            ST_FALL: begin
                if (!fade_en_i) begin
                    duty_d  = level_i ? FULL_DUTY : 8'd0;
                    state_d = level_i ? ST_ON : ST_OFF;
                end else if (level_i) begin
                    state_d = ST_RISE;
                end else if (period_end_i) begin
                    duty_d = duty_dn;
                    if (duty_dn == 8'd0) begin
                        state_d = ST_OFF;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            duty_q  <= 8'd0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            // Full duty is forced high so 255 gives a constant 1, not 255/256.
            led_q   <= (duty_q == FULL_DUTY) || (pwm_cnt_i < duty_q);
        end
    end

    assign led_o = led_q;

`ifdef LED_FADER_BUSY_EN
    assign fading_o = (state_q == ST_RISE) || (state_q == ST_FALL);
`endif

endmodule : led_fader_channel

// File: rtl/led_fader.sv
// Eight-channel LED PWM fader sharing one prescaler and PWM counter.
// Define LED_FADER_BUSY_EN to add the registered busy_o output.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned STEP     = DEFAULT_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] leds_i,
    input  logic       fade_en_i,
    output logic [7:0] led_o
`ifdef LED_FADER_BUSY_EN
    ,
    output logic       busy_o
`endif
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [7:0]  leds_q;
    logic [15:0] prescale_q, prescale_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        tick;
    logic        period_end;

    assign tick       = (prescale_q == PRESCALE_LAST);
    assign period_end = tick && (pwm_cnt_q == 8'hFF);
    assign prescale_d = tick ? 16'd0 : prescale_q + 16'd1;
    assign pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q     <= 8'd0;
            prescale_q <= 16'd0;
            pwm_cnt_q  <= 8'd0;
        end else begin
            leds_q     <= leds_i;
            prescale_q <= prescale_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

`ifdef LED_FADER_BUSY_EN
    logic [7:0] fading_w;
    logic       busy_q;
`endif

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            led_fader_channel #(
                .STEP(STEP)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .level_i     (leds_q[gi]),
                .fade_en_i   (fade_en_i),
                .period_end_i(period_end),
                .pwm_cnt_i   (pwm_cnt_q),
                .led_o       (led_o[gi])
`ifdef LED_FADER_BUSY_EN
                ,
                .fading_o    (fading_w[gi])
`endif
            );
        end
    endgenerate

`ifdef LED_FADER_BUSY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |fading_w;
        end
    end

    assign busy_o = busy_q;
`endif

endmodule : led_fader

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter PRESCALE, default 4: clocks per PWM tick; legal range 1..65535.
REQ-002 Parameter STEP, default 51: duty increment/decrement per fade step; legal range 1..255.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port leds_i, input, 8: target on/off pattern, driven directly by the LED register peripheral's leds_o.
REQ-006 Port fade_en_i, input, 1: 1 = gradual fading; 0 = duty snaps to target.
REQ-007 Port led_o, output, 8: registered PWM drive to the board LEDs; 1 = lit.
REQ-008 Port busy_o, output, 1: present only under LED_FADER_BUSY_EN (see REQ-027).

Function
REQ-009 leds_i SHALL be registered once into leds_q; all further logic SHALL use leds_q only.
REQ-010 The prescaler SHALL count 0..PRESCALE-1 and wrap; tick = (prescaler == PRESCALE-1).
REQ-011 The 8-bit pwm_cnt SHALL increment on tick only and wrap 255 -> 0; period_end = tick and pwm_cnt == 255.
REQ-012 Each LED i SHALL hold an 8-bit duty[i] and a state from OFF, RISE, ON, FALL.
REQ-013 Transitions: OFF->RISE when leds_q[i]=1; ON->FALL when leds_q[i]=0; RISE->FALL when leds_q[i]=0; FALL->RISE when leds_q[i]=1; RISE->ON when duty reaches 255; FALL->OFF when duty reaches 0.
REQ-014 A reversal mid-fade (RISE<->FALL) SHALL continue from the current duty with no jump.
REQ-015 On period_end with fade_en_i=1: RISE duty = min(duty+STEP, 255), FALL duty = max(duty-STEP, 0), computed with 9-bit intermediates; no wrap-around.
REQ-016 The state SHALL become ON/OFF in the same cycle the saturated duty becomes 255/0.
REQ-017 With fade_en_i=0, duty SHALL become 255 (leds_q=1) or 0 (leds_q=0) on the next clock, with state ON/OFF, independent of period_end.
REQ-018 Clearing fade_en_i mid-fade SHALL snap per REQ-017 on the next clock.
REQ-019 led_o[i] SHALL be registered as (duty[i] == 255) or (pwm_cnt < duty[i]).
REQ-020 Therefore duty 0 gives constant 0, duty 255 gives constant 1, and duty d gives exactly d high ticks per 256-tick period.
REQ-021 Latency from a leds_i edge: leds_q +1 clock; state change +2 clocks; snap-mode duty +3 clocks; led_o +4 clocks.
REQ-022 All 8 LEDs SHALL be independent, sharing only the prescaler and pwm_cnt.

Reset
REQ-023 While rst=1: prescaler=0, pwm_cnt=0, leds_q=0, duty=0, all states OFF, led_o=0, busy_o=0.
REQ-024 Reset asserted mid-fade SHALL abort the fade; after release, fading restarts from duty 0 toward leds_q.

Configuration
REQ-025 Macro LED_FADER_BUSY_EN selects the busy feature.
REQ-026 Without LED_FADER_BUSY_EN: the busy_o port and its logic SHALL be absent; all other behaviour is identical.
REQ-027 With LED_FADER_BUSY_EN: busy_o SHALL be a registered OR of (state == RISE or FALL) across all LEDs.

Structure
REQ-028 Package led_fader_pkg SHALL hold the 2-bit state enum (OFF=0, RISE=1, ON=2, FALL=3), the 255 full-duty constant and the default PRESCALE/STEP values.
REQ-029 Sub-module led_fader_channel SHALL hold one LED's state, duty and led_o flop, instantiated 8 times.
REQ-030 The top level SHALL hold leds_q, the prescaler, pwm_cnt and the busy logic.

Verification (PRESCALE=4, STEP=51; one PWM period = 1024 clocks)
REQ-031 Reset then leds_i=0x00 -> led_o=0x00 constantly; busy_o=0.
REQ-032 fade_en_i=1, leds_i 0x00->0x01 -> duty[0] = 51, 102, 153, 204, 255 at the next five period_ends; then state ON, led_o[0] constantly 1, busy_o low.
REQ-033 At duty 153 (RISE), set leds_i=0x00 -> FALL; duty 102, 51, 0 at the next three period_ends; then OFF.
REQ-034 STEP=200, RISE from 0 -> duty 200, then 255 (saturated, not 144); FALL from 255 -> 55, then 0.
REQ-035 fade_en_i=0, leds_i 0x00->0xA5 -> duty = 255 on bits 0, 2, 5, 7 at 3 clocks; led_o = 0xA5 at 4 clocks.
REQ-036 Duty 102 held -> led_o[0] high for exactly 408 clocks per 1024; rst pulsed mid-fade -> all outputs 0 on the next clock.
